// File: rtl/mfe_pkg.sv
// mfe_pkg: shared state encoding and width helpers for the mfe_seq sequencer.
`default_nettype none

package mfe_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_KEY  = 3'd0,
    ST_GEN_RND   = 3'd1,
    ST_OUT_KEY   = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_FEED      = 3'd4,
    ST_START     = 3'd5,
    ST_COMPUTE   = 3'd6,
    ST_DRAIN     = 3'd7
  } state_t;

  function automatic int idx_w(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic int key_frame_words(input int num_words);
    return 2 * num_words;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mfe_word_buf.sv
// mfe_word_buf: NUM_WORDS x DATA_WIDTH operand register file with a saturating
// write pointer and an independent indexed read port.
`default_nettype none

module mfe_word_buf
  import mfe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic                          wr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic [idx_w(NUM_WORDS)-1:0]   rd_idx_i,
  output logic [idx_w(NUM_WORDS)-1:0]   wr_ptr_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o
);

  localparam int IW = idx_w(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         ptr_d;

  // clr_i wins over the increment but never blocks the write it accompanies
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (wr_i && (ptr_q != LAST_IDX)) begin
      ptr_d = ptr_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (wr_i) begin
        mem_q[ptr_q] <= wr_data_i;
      end
    end
  end

  assign wr_ptr_o  = ptr_q;
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/mfe_seq.sv
// mfe_seq: key/exponent/data sequencer in front of a word-serial modexp engine.
// Optional periodic re-keying of the exponent is enabled by defining MFE_REKEY_EN.
`default_nettype none

module mfe_seq
  import mfe_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_WORDS    = 16,
  parameter int TIMEOUT      = 4096
`ifdef MFE_REKEY_EN
  , parameter int REKEY_BLOCKS = 256
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid_i,
  input  logic [DATA_WIDTH-1:0] key_data_i,
  output logic                  key_ready_o,
  input  logic                  rnd_valid_i,
  input  logic [DATA_WIDTH-1:0] rnd_data_i,
  output logic                  rnd_ready_o,
  input  logic                  din_valid_i,
  input  logic [DATA_WIDTH-1:0] din_data_i,
  output logic                  din_ready_o,
  input  logic                  key_reload_i,
  output logic                  dout_valid_o,
  output logic [DATA_WIDTH-1:0] dout_data_o,
  output logic                  dout_last_o,
  input  logic                  dout_ready_i,
  output logic                  eng_load_o,
  output logic [DATA_WIDTH-1:0] eng_m_o,
  output logic [DATA_WIDTH-1:0] eng_e_o,
  output logic [DATA_WIDTH-1:0] eng_n_o,
  output logic                  eng_start_o,
  input  logic                  eng_done_i,
  output logic                  eng_res_rd_o,
  input  logic [DATA_WIDTH-1:0] eng_res_i,
  output logic                  eng_clear_o,
  output logic                  busy_o,
  output logic                  error_o
);

  localparam int IW = idx_w(NUM_WORDS);
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
`ifdef MFE_REKEY_EN
  localparam int BW = cnt_w(REKEY_BLOCKS);
`endif

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  sel_q, sel_d;
  logic                  iss_done_q, iss_done_d;
  logic                  out_v_q, out_v_d;
  logic [DATA_WIDTH-1:0] out_d_q, out_d_d;
  logic                  out_l_q, out_l_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  error_q, error_d;
  logic                  eng_clear_q, eng_clear_d;
  logic                  rst_seen_q;
  logic                  reload_pend_q, reload_pend_d;
`ifdef MFE_REKEY_EN
  logic [BW-1:0]         blk_q, blk_d;
`endif

  logic                  k_wr_d, k_clr_d, e_wr_d, e_clr_d, m_wr_d, m_clr_d;
  logic [IW-1:0]         k_ptr_q, e_ptr_q, m_ptr_q;
  logic [DATA_WIDTH-1:0] n_rd_d, e_rd_d, m_rd_d;
  logic                  take_d, can_load_d, reload_req_d;

  mfe_word_buf #(.DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS)) u_n_buf (
    .clk(clk), .rst(rst), .clr_i(k_clr_d), .wr_i(k_wr_d), .wr_data_i(key_data_i),
    .rd_idx_i(idx_q), .wr_ptr_o(k_ptr_q), .rd_data_o(n_rd_d)
  );

  mfe_word_buf #(.DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS)) u_e_buf (
    .clk(clk), .rst(rst), .clr_i(e_clr_d), .wr_i(e_wr_d), .wr_data_i(rnd_data_i),
    .rd_idx_i(idx_q), .wr_ptr_o(e_ptr_q), .rd_data_o(e_rd_d)
  );

  mfe_word_buf #(.DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS)) u_m_buf (
    .clk(clk), .rst(rst), .clr_i(m_clr_d), .wr_i(m_wr_d), .wr_data_i(din_data_i),
    .rd_idx_i(idx_q), .wr_ptr_o(m_ptr_q), .rd_data_o(m_rd_d)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sel_d         = sel_q;
    iss_done_d    = iss_done_q;
    out_v_d       = out_v_q;
    out_d_d       = out_d_q;
    out_l_d       = out_l_q;
    pend_d        = pend_q;
    pend_last_d   = pend_last_q;
    tmo_d         = tmo_q;
    error_d       = error_q;
    eng_clear_d   = rst_seen_q;
    reload_pend_d = reload_pend_q;
`ifdef MFE_REKEY_EN
    blk_d         = blk_q;
`endif
    key_ready_o   = 1'b0;
    rnd_ready_o   = 1'b0;
    din_ready_o   = 1'b0;
    eng_load_o    = 1'b0;
    eng_start_o   = 1'b0;
    eng_res_rd_o  = 1'b0;
    k_wr_d        = 1'b0;
    k_clr_d       = 1'b0;
    e_wr_d        = 1'b0;
    e_clr_d       = 1'b0;
    m_wr_d        = 1'b0;
    m_clr_d       = 1'b0;

    reload_req_d = key_reload_i | reload_pend_q;
    take_d       = out_v_q & dout_ready_i;
    can_load_d   = ~out_v_q | take_d;

    if (take_d) begin
      out_v_d = 1'b0;
    end
    // a result popped last cycle lands in the output register now
    if (pend_q) begin
      out_v_d = 1'b1;
      out_d_d = eng_res_i;
      out_l_d = pend_last_q;
      pend_d  = 1'b0;
    end

    case (state_q)
      ST_LOAD_KEY: begin
        key_ready_o = ~reload_req_d;
        k_wr_d      = key_valid_i & key_ready_o;
        if (k_wr_d && (k_ptr_q == LAST_IDX)) begin
          k_clr_d = 1'b1;
          state_d = ST_GEN_RND;
`ifdef MFE_REKEY_EN
          blk_d   = '0;
`endif
        end
      end

      ST_GEN_RND: begin
        rnd_ready_o = 1'b1;
        // an all-zero most significant exponent word is consumed but discarded
        e_wr_d = rnd_valid_i & ~((e_ptr_q == LAST_IDX) && (rnd_data_i == '0));
        if (e_wr_d && (e_ptr_q == LAST_IDX)) begin
          e_clr_d    = 1'b1;
          state_d    = ST_OUT_KEY;
          idx_d      = '0;
          sel_d      = 1'b0;
          iss_done_d = 1'b0;
        end
      end

      ST_OUT_KEY: begin
        if (can_load_d && !iss_done_q) begin
          out_v_d = 1'b1;
          out_d_d = sel_q ? e_rd_d : n_rd_d;
          out_l_d = sel_q && (idx_q == LAST_IDX);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (sel_q) begin
              iss_done_d = 1'b1;
            end else begin
              sel_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        if (take_d && out_l_q) begin
          state_d = ST_WAIT_DATA;
        end
      end

      ST_WAIT_DATA: begin
        din_ready_o = ~reload_req_d;
        m_wr_d      = din_valid_i & din_ready_o;
        if (m_wr_d && (m_ptr_q == LAST_IDX)) begin
          m_clr_d = 1'b1;
          state_d = ST_FEED;
          idx_d   = '0;
        end
      end

      ST_FEED: begin
        eng_load_o = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_START;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      ST_START: begin
        eng_start_o = 1'b1;
        tmo_d       = TW'(1);
        state_d     = ST_COMPUTE;
      end

      ST_COMPUTE: begin
        if (eng_done_i) begin
          state_d    = ST_DRAIN;
          idx_d      = '0;
          iss_done_d = 1'b0;
        end else if (tmo_q >= TW'(TIMEOUT)) begin
          error_d     = 1'b1;
          eng_clear_d = 1'b1;
          state_d     = ST_WAIT_DATA;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_DRAIN: begin
        // pop only when the popped word is guaranteed a free output slot
        if (!iss_done_q && !pend_q && can_load_d) begin
          eng_res_rd_o = 1'b1;
          pend_d       = 1'b1;
          pend_last_d  = (idx_q == LAST_IDX);
          if (idx_q == LAST_IDX) begin
            iss_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        if (take_d && out_l_q) begin
`ifdef MFE_REKEY_EN
          if (blk_q == BW'(REKEY_BLOCKS - 1)) begin
            blk_d   = '0;
            state_d = ST_GEN_RND;
          end else begin
            blk_d   = blk_q + BW'(1);
            state_d = ST_WAIT_DATA;
          end
`else
          state_d = ST_WAIT_DATA;
`endif
        end
      end

      default: state_d = ST_LOAD_KEY;
    endcase

    if ((state_q == ST_WAIT_DATA || state_q == ST_LOAD_KEY) && reload_req_d) begin
      state_d       = ST_LOAD_KEY;
      idx_d         = '0;
      k_clr_d       = 1'b1;
      e_clr_d       = 1'b1;
      m_clr_d       = 1'b1;
      error_d       = 1'b0;
      eng_clear_d   = 1'b1;
      reload_pend_d = 1'b0;
    end else if (key_reload_i) begin
      reload_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD_KEY;
      idx_q         <= '0;
      sel_q         <= 1'b0;
      iss_done_q    <= 1'b0;
      out_v_q       <= 1'b0;
      out_d_q       <= '0;
      out_l_q       <= 1'b0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      tmo_q         <= '0;
      error_q       <= 1'b0;
      eng_clear_q   <= 1'b0;
      rst_seen_q    <= 1'b1;
      reload_pend_q <= 1'b0;
`ifdef MFE_REKEY_EN
      blk_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sel_q         <= sel_d;
      iss_done_q    <= iss_done_d;
      out_v_q       <= out_v_d;
      out_d_q       <= out_d_d;
      out_l_q       <= out_l_d;
      pend_q        <= pend_d;
      pend_last_q   <= pend_last_d;
      tmo_q         <= tmo_d;
      error_q       <= error_d;
      eng_clear_q   <= eng_clear_d;
      rst_seen_q    <= 1'b0;
      reload_pend_q <= reload_pend_d;
`ifdef MFE_REKEY_EN
      blk_q         <= blk_d;
`endif
    end
  end

  assign dout_valid_o = out_v_q;
  assign dout_data_o  = out_d_q;
  assign dout_last_o  = out_l_q;
  assign eng_m_o      = eng_load_o ? m_rd_d : '0;
  assign eng_e_o      = eng_load_o ? e_rd_d : '0;
  assign eng_n_o      = eng_load_o ? n_rd_d : '0;
  assign eng_clear_o  = eng_clear_q;
  assign error_o      = error_q;
  assign busy_o       = (state_q != ST_WAIT_DATA) && (state_q != ST_LOAD_KEY);

endmodule

`default_nettype wire
